nco_freq_ramp_ctrl: RTL
=======================

// Module: nco_freq_ramp_ctrl
// PURPOSE
//  Sequencer for the NCO frequency word. Accepts target frequency words on an AXI-Stream
//  slave, then jumps or ramps FREQ_WORD toward the target in fixed steps at a programmable rate.
//  Sits between host/loop-filter logic and the NCO FREQ_WORD input.
//  Gives phase-continuous, rate-limited frequency changes for the dissemination link.
// PARAMETERS
//  ACCUM_WIDTH  32  width of frequency word / NCO accumulator
//  STEP_WIDTH   24  width of ramp step magnitude (zero-extended to ACCUM_WIDTH)
//  DIV_WIDTH    16  width of step-interval divider
//  RESET_FREQ   0   FREQ_WORD value after reset
// PORTS
//  clk            in   1            single clock; all logic on rising edge
//  rst_n          in   1            asynchronous, active-low reset
//  s_axis_tdata   in   ACCUM_WIDTH  target frequency word (unsigned)
//  s_axis_tvalid  in   1            target valid
//  s_axis_tready  out  1            high only in IDLE
//  step           in   STEP_WIDTH   ramp step magnitude, sampled at accept
//  div            in   DIV_WIDTH    extra cycles between steps (0 = step every cycle), sampled at accept
//  jump           in   1            sampled at accept: 1 = load target directly
//  abort          in   1            in RAMP: freeze FREQ_WORD at current value, return to IDLE
//  freq_min       in   ACCUM_WIDTH  lower clamp (used only with NCO_RAMP_CLAMP_EN)
//  freq_max       in   ACCUM_WIDTH  upper clamp (used only with NCO_RAMP_CLAMP_EN)
//  freq_word      out  ACCUM_WIDTH  registered word to NCO FREQ_WORD
//  busy           out  1            high in RAMP
//  done           out  1            1-cycle pulse when freq_word reaches target
//  aborted        out  1            1-cycle pulse when a ramp is aborted
// BEHAVIOUR
//  Reset: freq_word=RESET_FREQ, busy=0, done=0, aborted=0, state=IDLE, s_axis_tready=1 after reset.
//  States: IDLE, RAMP.
//  IDLE: accept on tvalid&tready (edge k); latch target (clamped if enabled), step, div.
//   - jump=1, step==0, or target==freq_word: freq_word<=target at edge k; done=1 in cycle k+1; stay IDLE.
//   - otherwise: enter RAMP, load tick counter with div.
//  RAMP: tready=0, busy=1; tvalid held by source (no retarget mid-ramp).
//   - tick counter decrements each cycle; when 0, apply step and reload with div.
//   - first step lands div+1 edges after accept edge; steps spaced div+1 cycles.
//   - step: diff = target-freq_word computed ACCUM_WIDTH+1 bits signed; no modular wrap.
//     |diff| <= step: freq_word<=target, done pulse, -> IDLE; else freq_word += / -= step.
//   - abort=1: freq_word holds, aborted pulse next cycle, -> IDLE; abort has priority over a step same cycle.
//  abort in IDLE ignored (accept proceeds if tvalid). done/aborted never both high.
//  Async reset mid-ramp: immediate return to reset values; in-flight target discarded.
// CONFIGURATION
//  `NCO_RAMP_CLAMP_EN defined: latched target = min(max(tdata,freq_min),freq_max); if freq_min>freq_max, freq_min wins.
//  Not defined: target = tdata unmodified; freq_min/freq_max ports present but ignored.
// STRUCTURE
//  nco_ctrl_pkg: state enum {IDLE,RAMP}, default width constants, ramp-step function.
//  Sub-module nco_ramp_tick: DIV_WIDTH down-counter with load/enable, outputs 1-cycle tick.
// TESTING
//  1 reset, RESET_FREQ=0x100 -> freq_word=0x100, tready=1, busy=0, done=0.
//  2 tdata=0x1000,jump=1 -> freq_word=0x1000 next cycle, done 1 cycle, no busy.
//  3 from 0, tdata=0x0A, step=3, div=1 -> 3,6,9,0x0A every 2 cycles; done with 0x0A.
//  4 from 0x0A, tdata=0x00, step=4, div=0 -> 6,2,0 consecutive cycles; done with 0.
//  5 ramp 0->0x100 step=1 div=0, abort at 5th cycle -> freq_word frozen, aborted pulse, tready=1.
//  6 clamp on, freq_max=0x80, tdata=0x200 jump=1 -> freq_word=0x80; clamp off -> 0x200.

Source files
------------

// File: rtl/nco_ctrl_pkg.sv
// Shared types and the ramp-step arithmetic for the NCO frequency-word sequencer.
package nco_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } nco_state_e;

  localparam int unsigned NCO_ACCUM_WIDTH_DEF = 32;
  localparam int unsigned NCO_STEP_WIDTH_DEF  = 24;
  localparam int unsigned NCO_DIV_WIDTH_DEF   = 16;

  // Arithmetic is carried out at a fixed wide width; callers zero-extend and truncate.
  localparam int unsigned NCO_CALC_WIDTH = 64;

  typedef logic [NCO_CALC_WIDTH-1:0] nco_word_t;

  typedef struct packed {
    nco_word_t next;
    logic      reached;
  } nco_step_t;

  // One ramp step toward target; the difference is signed one bit wider so it never wraps.
  function automatic nco_step_t nco_ramp_step(input nco_word_t cur,
                                              input nco_word_t target,
                                              input nco_word_t step);
    logic signed [NCO_CALC_WIDTH:0] diff;
    logic        [NCO_CALC_WIDTH:0] mag;
    nco_step_t                      res;
    diff = $signed({1'b0, target}) - $signed({1'b0, cur});
    mag  = diff[NCO_CALC_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    if (mag <= {1'b0, step}) begin
      res.next    = target;
      res.reached = 1'b1;
    end else if (diff[NCO_CALC_WIDTH]) begin
      res.next    = cur - step;
      res.reached = 1'b0;
    end else begin
      res.next    = cur + step;
      res.reached = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/nco_ramp_tick.sv
// Step-interval down-counter: emits a tick every (period+1) enabled cycles after a load.
import nco_ctrl_pkg::*;

module nco_ramp_tick #(
  parameter int unsigned DIV_WIDTH = NCO_DIV_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_val,
  input  logic                 en,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] period_q;
  logic [DIV_WIDTH-1:0] cnt_q;

  assign tick = en && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      period_q <= load_val;
      cnt_q    <= load_val;
    end else if (en) begin
      if (cnt_q == '0) begin
        cnt_q <= period_q;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/nco_freq_ramp_ctrl.sv
// NCO frequency-word sequencer: jumps or rate-limited ramps toward AXI-Stream targets.
// Optional target clamping to [freq_min, freq_max] when NCO_RAMP_CLAMP_EN is defined.
import nco_ctrl_pkg::*;

module nco_freq_ramp_ctrl #(
  parameter int unsigned          ACCUM_WIDTH = NCO_ACCUM_WIDTH_DEF,
  parameter int unsigned          STEP_WIDTH  = NCO_STEP_WIDTH_DEF,
  parameter int unsigned          DIV_WIDTH   = NCO_DIV_WIDTH_DEF,
  parameter logic [ACCUM_WIDTH-1:0] RESET_FREQ = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ACCUM_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [STEP_WIDTH-1:0]  step,
  input  logic [DIV_WIDTH-1:0]   div,
  input  logic                   jump,
  input  logic                   abort,
  input  logic [ACCUM_WIDTH-1:0] freq_min,
  input  logic [ACCUM_WIDTH-1:0] freq_max,
  output logic [ACCUM_WIDTH-1:0] freq_word,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted
);

  nco_state_e              state_q, state_d;
  logic [ACCUM_WIDTH-1:0]  freq_q, freq_d;
  logic [ACCUM_WIDTH-1:0]  target_q, target_d;
  logic [STEP_WIDTH-1:0]   step_q, step_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;

  logic                    accept;
  logic                    immediate;
  logic                    tick;
  logic [ACCUM_WIDTH-1:0]  target_in;
  nco_step_t               step_res;

  assign accept        = s_axis_tvalid && (state_q == IDLE);
  assign s_axis_tready = (state_q == IDLE);
  assign busy          = (state_q == RAMP);
  assign freq_word     = freq_q;
  assign done          = done_q;
  assign aborted       = aborted_q;

`ifdef NCO_RAMP_CLAMP_EN
  // An inverted window collapses onto freq_min rather than freq_max.
  always_comb begin
    target_in = s_axis_tdata;
    if (freq_min > freq_max) begin
      target_in = freq_min;
    end else if (s_axis_tdata < freq_min) begin
      target_in = freq_min;
    end else if (s_axis_tdata > freq_max) begin
      target_in = freq_max;
    end
  end
`else
  logic unused_clamp;
  assign unused_clamp = ^{freq_min, freq_max};
  assign target_in    = s_axis_tdata;
`endif

  assign immediate = jump || (step == '0) || (target_in == freq_q);

  assign step_res = nco_ramp_step(nco_word_t'(freq_q),
                                  nco_word_t'(target_q),
                                  nco_word_t'(step_q));

  generate
    if (ACCUM_WIDTH < NCO_CALC_WIDTH) begin : g_unused_hi
      logic unused_step_hi;
      assign unused_step_hi = ^step_res.next[NCO_CALC_WIDTH-1:ACCUM_WIDTH];
    end
  endgenerate

  nco_ramp_tick #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && !immediate),
    .load_val (div),
    .en       ((state_q == RAMP) && !abort),
    .tick     (tick)
  );

  always_comb begin
    state_d   = state_q;
    freq_d    = freq_q;
    target_d  = target_q;
    step_d    = step_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = target_in;
          step_d   = step;
          if (immediate) begin
            freq_d = target_in;
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (tick) begin
          freq_d = step_res.next[ACCUM_WIDTH-1:0];
          if (step_res.reached) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q    <= RESET_FREQ;
      target_q  <= RESET_FREQ;
      step_q    <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      freq_q    <= freq_d;
      target_q  <= target_d;
      step_q    <= step_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

endmodule
